bmp_window_builder: RTL and testbench
=====================================

Name: bmp_window_builder

Overview:
- Consumes the 16-bit packed BMP word stream produced by the image loader stage and discards the 54-byte header.
- Unpacks two 8-bit grayscale pixels per word and buffers two full image rows.
- Emits every complete 3x3 pixel neighbourhood, with its centre coordinate, to the downstream Sobel edge-detect stage over a valid/ready handshake.

Parameters:
- WIDTH, 128, pixels per row; even, at least 3.
- DEPTH, 128, rows per frame; at least 3.
- HDR_WORDS, 27, leading 16-bit header words discarded per frame (54 bytes / 2).
- XW, $clog2(WIDTH), width of the x coordinate.
- YW, $clog2(DEPTH), width of the y coordinate.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  16  packed word; [15:8] is the earlier pixel, [7:0] the later pixel.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle.
- win  out  72  3x3 window, row-major, top-left in [71:64], bottom-right in [7:0].
- win_cx  out  XW  x of the window centre.
- win_cy  out  YW  y of the window centre.
- out_valid  out  1  win, win_cx and win_cy are valid.
- out_ready  in  1  downstream accepts the window.
- frame_done  out  1  one-cycle pulse at the end of a frame.

Behaviour:
- Reset (asynchronous, rst_n low): state=HEADER, hdr_cnt=0, x=0, y=0, hold_valid=0, phase=0.
  - Outputs during reset: out_valid=0, frame_done=0, win=0, win_cx=0, win_cy=0.
  - Line-buffer contents are don't-care.
- Input transfer: occurs when in_valid && in_ready.
  - in_ready=1 in HEADER.
  - in_ready=!hold_valid in PIXELS.
  - in_ready=0 in DONE.
- FSM states: HEADER, PIXELS, DONE.
  - HEADER: each transfer increments hdr_cnt. The transfer at hdr_cnt==HDR_WORDS-1 moves to PIXELS and clears hdr_cnt. Data is discarded.
  - PIXELS: a transfer loads hold_reg and sets hold_valid=1, phase=0.
  - Pixel advance condition: hold_valid && (!out_valid || out_ready).
  - Pixel selection: phase 0 uses hold_reg[15:8]; phase 1 uses hold_reg[7:0], then hold_valid clears.
  - Each advanced pixel p at (x,y):
    - Shift the 3x3 register left by one column.
    - New right column is {lb1[x], lb0[x], p}, top to bottom.
    - Then write lb1[x]<=lb0[x] and lb0[x]<=p.
    - x increments; at x==WIDTH-1, x wraps to 0 and y increments.
  - Window emission: if x>=2 && y>=2 at advance, the next cycle has out_valid=1, win set, win_cx=x-1, win_cy=y-1.
  - Output hold: if the advance produces no window and out_valid && out_ready, out_valid clears.
  - Stability: out_valid && !out_ready holds win, win_cx and win_cy stable and stalls advance. in_ready stays low while hold_valid=1.
  - End of frame: advance of pixel (WIDTH-1, DEPTH-1) goes to DONE, resets x and y to 0, and asserts frame_done on the next cycle (the same cycle the last window's out_valid rises).
  - DONE: lasts exactly one cycle (frame_done=1), then returns to HEADER.
- Throughput: maximum 2 pixels per 3 cycles, because in_ready stays low while a word is held.
- Boundaries:
  - Column 0 and 1 pixels of each row produce no window; the shift register carries stale columns that are never emitted.
  - Rows 0 and 1 produce no window.
  - Windows per frame: (WIDTH-2)*(DEPTH-2) = 15876 at default parameters.
- Row order: no vertical flip. Rows are numbered in arrival order.
- Trailing input: words after the last pixel word are treated as the next frame's header.
- Reset mid-frame: the next frame restarts with header skipping. No window or frame_done is generated from pre-reset data.

Test Plan:
- Reset checks:
  - Assert rst_n=0 mid-clock -> out_valid=0, frame_done=0 and in_ready=1 immediately.
  - After release, in_ready=1.
  - 27 header words of 0xFFFF produce no out_valid.
- Ramp first window:
  - Stimulus: pixel p(x,y)=(3y+x)&0xFF, sent with no backpressure.
  - First out_valid gives win=0x000102030405060708, win_cx=1, win_cy=1.
  - Final window gives win=0xF4F5F6F7F8F9FAFBFC, win_cx=126, win_cy=126.
- Window count:
  - Full frame (27+8192 words) -> exactly 15876 out_valid handshakes.
  - Exactly one frame_done pulse, coincident with the final window.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles on the first window.
  - win, win_cx and win_cy stay stable; in_ready=0 once hold_valid=1.
  - No windows lost or duplicated; per-coordinate values match the model.
- Back-to-back frames:
  - Send two ramp frames with no gap.
  - The second frame's first window is again 0x000102030405060708 at (1,1).
  - Two frame_done pulses in total.
- Reset mid-frame:
  - Stimulus: assert rst_n=0 after 3000 pixel words, then send a full frame.
  - Exactly 15876 windows are produced, all matching the ramp model, and one frame_done pulse.

Source files
------------

// File: rtl/bmp_window_builder.sv
// rtl/bmp_window_builder.sv - builds 3x3 pixel windows from a packed 16-bit BMP word stream
//
// Drops HDR_WORDS header words per frame, unpacks two 8-bit pixels per word
// (upper byte first), keeps the previous two rows in line buffers and emits
// every complete 3x3 neighbourhood with its centre coordinate.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_data/in_valid/in_ready      packed pixel word stream in
//   win/win_cx/win_cy/out_valid/out_ready  window stream out
//                       (win row-major, top-left in [71:64])
//   frame_done          one-cycle pulse when the last pixel of a frame is taken
module bmp_window_builder #(
  parameter int WIDTH     = 128,
  parameter int DEPTH     = 128,
  parameter int HDR_WORDS = 27,
  parameter int XW        = $clog2(WIDTH),
  parameter int YW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [15:0]   in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [71:0]   win,
  output logic [XW-1:0] win_cx,
  output logic [YW-1:0] win_cy,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          frame_done
);

  localparam int HW = (HDR_WORDS > 1) ? $clog2(HDR_WORDS) : 1;

  typedef enum logic [1:0] {S_HEADER, S_PIXELS, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] hdr_cnt_q, hdr_cnt_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [15:0]   hold_reg_q, hold_reg_d;
  logic          hold_valid_q, hold_valid_d;
  logic          phase_q, phase_d;
  logic [71:0]   win_q, win_d;
  logic [XW-1:0] win_cx_q, win_cx_d;
  logic [YW-1:0] win_cy_q, win_cy_d;
  logic          out_valid_q, out_valid_d;
  logic          frame_done_q, frame_done_d;

  // lb0 holds the previous row, lb1 the row before that
  logic [7:0] lb0_q [WIDTH];
  logic [7:0] lb1_q [WIDTH];

  logic       in_xfer;
  logic       advance;
  logic       emit;
  logic [7:0] pix;
  logic [7:0] lb0_rd;
  logic [7:0] lb1_rd;

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      S_HEADER: in_ready = 1'b1;
      S_PIXELS: in_ready = !hold_valid_q;
      default:  in_ready = 1'b0;
    endcase
  end

  assign in_xfer = in_valid && in_ready;
  // A held pixel moves only when the output slot is free or being drained,
  // so a stalled window is never overwritten.
  assign advance = (state_q == S_PIXELS) && hold_valid_q && (!out_valid_q || out_ready);
  assign pix     = phase_q ? hold_reg_q[7:0] : hold_reg_q[15:8];
  assign lb0_rd  = lb0_q[x_q];
  assign lb1_rd  = lb1_q[x_q];
  assign emit    = advance && (x_q >= XW'(2)) && (y_q >= YW'(2));

  always_comb begin
    state_d      = state_q;
    hdr_cnt_d    = hdr_cnt_q;
    x_d          = x_q;
    y_d          = y_q;
    hold_reg_d   = hold_reg_q;
    hold_valid_d = hold_valid_q;
    phase_d      = phase_q;
    win_d        = win_q;
    win_cx_d     = win_cx_q;
    win_cy_d     = win_cy_q;
    out_valid_d  = out_valid_q;
    frame_done_d = 1'b0;

    case (state_q)
      S_HEADER: begin
        if (in_xfer) begin
          if (hdr_cnt_q == HW'(HDR_WORDS - 1)) begin
            hdr_cnt_d = '0;
            state_d   = S_PIXELS;
          end else begin
            hdr_cnt_d = hdr_cnt_q + HW'(1);
          end
        end
      end
      S_PIXELS: begin
        if (in_xfer) begin
          hold_reg_d   = in_data;
          hold_valid_d = 1'b1;
          phase_d      = 1'b0;
        end
        if (advance) begin
          // shift left one column; new right column is {lb1, lb0, pix}
          win_d = {win_q[63:48], lb1_rd, win_q[39:24], lb0_rd, win_q[15:0], pix};
          phase_d = !phase_q;
          if (phase_q) begin
            hold_valid_d = 1'b0;
          end
          if (x_q == XW'(WIDTH - 1)) begin
            x_d = '0;
            if (y_q == YW'(DEPTH - 1)) begin
              y_d          = '0;
              state_d      = S_DONE;
              frame_done_d = 1'b1;
            end else begin
              y_d = y_q + YW'(1);
            end
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_HEADER;
      end
      default: begin
        state_d = S_HEADER;
      end
    endcase

    if (emit) begin
      out_valid_d = 1'b1;
      win_cx_d    = x_q - XW'(1);
      win_cy_d    = y_q - YW'(1);
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_HEADER;
      hdr_cnt_q    <= '0;
      x_q          <= '0;
      y_q          <= '0;
      hold_reg_q   <= '0;
      hold_valid_q <= 1'b0;
      phase_q      <= 1'b0;
      win_q        <= '0;
      win_cx_q     <= '0;
      win_cy_q     <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hdr_cnt_q    <= hdr_cnt_d;
      x_q          <= x_d;
      y_q          <= y_d;
      hold_reg_q   <= hold_reg_d;
      hold_valid_q <= hold_valid_d;
      phase_q      <= phase_d;
      win_q        <= win_d;
      win_cx_q     <= win_cx_d;
      win_cy_q     <= win_cy_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line buffers need no reset: rows 0 and 1 of every frame refill them
  // before any window that reads them can be emitted.
  always_ff @(posedge clk) begin
    if (advance) begin
      lb1_q[x_q] <= lb0_rd;
      lb0_q[x_q] <= pix;
    end
  end

  assign win        = win_q;
  assign win_cx     = win_cx_q;
  assign win_cy     = win_cy_q;
  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bmp_window_builder.sv
// tb/tb_bmp_window_builder.sv - self-checking bench for bmp_window_builder
module tb_bmp_window_builder;

  localparam int W   = 128;
  localparam int D   = 128;
  localparam int HDR = 27;
  localparam int XW  = 7;
  localparam int YW  = 7;

  logic          clk;
  logic          rst_n;
  logic [15:0]   in_data;
  logic          in_valid;
  logic          in_ready;
  logic [71:0]   win;
  logic [XW-1:0] win_cx;
  logic [YW-1:0] win_cy;
  logic          out_valid;
  logic          out_ready;
  logic          frame_done;

  bmp_window_builder #(
    .WIDTH(W), .DEPTH(D), .HDR_WORDS(HDR), .XW(XW), .YW(YW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .win(win), .win_cx(win_cx), .win_cy(win_cy),
    .out_valid(out_valid), .out_ready(out_ready),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [71:0] win;
    int          cx;
    int          cy;
    int          frame;
  } exp_t;

  typedef struct {
    int          frame;
    int          cx;
    int          cy;
    logic [71:0] win;
  } vec_t;

  exp_t        exp_q[$];
  int          tests;
  int          fails;
  int          n_win;
  int          n_fd;
  bit          ov_any;
  bit          bp_arm;
  bit          rnd_bp;
  logic [71:0] cap [2][W][D];

  function automatic logic [7:0] pix(input int x, input int y);
    return 8'((3 * y + x) & 255);
  endfunction

  function automatic logic [71:0] model_win(input int cx, input int cy);
    logic [71:0] w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w = {w[63:0], pix(cx - 1 + c, cy - 1 + r)};
    return w;
  endfunction

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic give_up(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting on DUT", name);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  // Called at posedge+1; returns at posedge+1 after the word was taken.
  task automatic send_word(input logic [15:0] d, input int px, input int py, input int frame);
    bit   acc;
    int   n;
    exp_t e;
    in_data  = d;
    in_valid = 1'b1;
    acc      = 1'b0;
    n        = 0;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
      if (!acc && n > 200) give_up("in_ready_wait");
    end
    in_valid = 1'b0;
    if (px >= 0) begin
      for (int k = 0; k < 2; k++) begin
        if (px + k >= 2 && py >= 2) begin
          e.win   = model_win(px + k - 1, py - 1);
          e.cx    = px + k - 1;
          e.cy    = py - 1;
          e.frame = frame;
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic send_header();
    for (int i = 0; i < HDR; i++) send_word(16'hFFFF, -1, 0, -1);
  endtask

  task automatic send_pixels(input int frame, input int nwords);
    for (int i = 0; i < nwords; i++) begin
      int x;
      int y;
      x = (2 * i) % W;
      y = (2 * i) / W;
      send_word({pix(x, y), pix(x + 1, y)}, x, y, frame);
    end
  endtask

  // Output monitor and scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (out_valid) ov_any = 1'b1;
        if (frame_done) begin
          n_fd++;
          check("frame_done_with_last_win", {out_valid, win_cx, win_cy},
                {1'b1, XW'(W - 2), YW'(D - 2)});
        end
        if (out_valid && out_ready) begin
          n_win++;
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_win: got %h at (%0d,%0d), want none", win, win_cx, win_cy);
          end else begin
            e = exp_q.pop_front();
            check("win", win, e.win);
            check("win_coord", {win_cx, win_cy}, {XW'(e.cx), YW'(e.cy)});
            if (e.frame >= 0) cap[e.frame][e.cx][e.cy] = win;
          end
        end
      end
    end
  end

  // out_ready driver: one 10-cycle stall on the first armed window, else
  // optional random backpressure.
  initial begin
    logic [71:0] w0;
    logic [13:0] c0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_arm && rst_n && out_valid) begin
        bp_arm    = 1'b0;
        w0        = win;
        c0        = {win_cx, win_cy};
        out_ready = 1'b0;
        repeat (10) begin
          @(negedge clk);
          check("bp_win_stable", win, w0);
          check("bp_coord_stable", {win_cx, win_cy}, c0);
          check("bp_out_valid", out_valid, 1'b1);
          check("bp_in_ready_low", in_ready, 1'b0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end else begin
        out_ready = rnd_bp ? ($urandom_range(0, 7) != 0) : 1'b1;
      end
    end
  end

  vec_t vecs [10];

  initial begin
    int n;
    vecs[0] = '{0, 1,   1,   72'h000102030405060708};
    vecs[1] = '{0, 126, 126, 72'hF4F5F6F7F8F9FAFBFC};
    vecs[2] = '{0, 1,   2,   72'h030405060708090A0B};
    vecs[3] = '{0, 126, 1,   72'h7D7E7F808182838485};
    vecs[4] = '{0, 64,  64,  72'hFCFDFEFF0001020304};
    vecs[5] = '{1, 1,   1,   72'h000102030405060708};
    vecs[6] = '{1, 126, 126, 72'hF4F5F6F7F8F9FAFBFC};
    vecs[7] = '{1, 1,   2,   72'h030405060708090A0B};
    vecs[8] = '{1, 126, 1,   72'h7D7E7F808182838485};
    vecs[9] = '{1, 64,  64,  72'hFCFDFEFF0001020304};

    tests    = 0;
    fails    = 0;
    n_win    = 0;
    n_fd     = 0;
    ov_any   = 1'b0;
    bp_arm   = 1'b0;
    rnd_bp   = 1'b0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_frame_done", frame_done, 1'b0);
    check("reset_win", win, 72'h0);
    check("reset_coord", {win_cx, win_cy}, 14'h0);
    check("reset_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_in_ready", in_ready, 1'b1);

    // Partial frame, then reset in the middle of a clock period.
    ov_any = 1'b0;
    send_header();
    check("header_no_out_valid", ov_any, 1'b0);
    send_pixels(-1, 3000);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", out_valid, 1'b0);
    check("midreset_frame_done", frame_done, 1'b0);
    check("midreset_in_ready", in_ready, 1'b1);
    exp_q.delete();
    n_win = 0;
    n_fd  = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("midreset_release_in_ready", in_ready, 1'b1);

    // Two full frames back to back; first window of the first one is stalled.
    bp_arm = 1'b1;
    send_header();
    send_pixels(0, W * D / 2);
    rnd_bp = 1'b1;
    send_header();
    send_pixels(1, W * D / 2);

    n = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk);
      n++;
      if (n > 2000) give_up("drain");
    end
    rnd_bp = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    check("window_count", n_win, 2 * (W - 2) * (D - 2));
    check("frame_done_count", n_fd, 2);
    check("scoreboard_empty", exp_q.size(), 0);
    check("bp_done", bp_arm, 1'b0);
    check("idle_in_ready", in_ready, 1'b1);
    check("idle_out_valid", out_valid, 1'b0);

    for (int i = 0; i < 10; i++)
      check($sformatf("landmark_f%0d_(%0d,%0d)", vecs[i].frame, vecs[i].cx, vecs[i].cy),
            cap[vecs[i].frame][vecs[i].cx][vecs[i].cy], vecs[i].win);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
